// File: rtl/code_lock_prog_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// code_lock_prog_pkg : state encoding and width helpers for the code lock
// Rev 1.0
// ---------------------------------------------------------------------------
package code_lock_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTER    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_PROGRAM  = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_e;

  // Width of an index that must be able to hold 0..code_len.
  function automatic int idx_width(input int code_len);
    return $clog2(code_len + 1);
  endfunction

  function automatic int timer_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_prog_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lock_timer : loadable up/down cycle counter with terminal-count compare
// Rev 1.0
// ---------------------------------------------------------------------------
module lock_timer
  import code_lock_prog_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)       cnt_d = '0;
    else if (i_load) cnt_d = i_load_val;
    else if (i_inc)  cnt_d = cnt_q + 1'b1;
    else if (i_dec)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tc = (cnt_q == i_term);

endmodule
`default_nettype wire

// File: rtl/code_lock_prog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// code_lock_prog : programmable code-lock Moore FSM with timeout and lockout
// Rev 1.0
// ---------------------------------------------------------------------------
module code_lock_prog
  import code_lock_prog_pkg::*;
#(
  parameter int                            KEY_W        = 4,
  parameter int                            CODE_LEN     = 4,
  parameter logic [CODE_LEN*KEY_W-1:0]     DEFAULT_CODE = 16'h2841,
  parameter int                            TIMEOUT_CYC  = 32,
  parameter int                            MAX_FAIL     = 3,
  parameter int                            LOCKOUT_CYC  = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [KEY_W-1:0]                keys,
  input  logic                            lock_cmd,
  input  logic                            prog_req,
  output logic                            unlock,
  output logic [CODE_LEN-1:0]             progress,
  output logic                            programming,
  output logic                            locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CW = CODE_LEN * KEY_W;
  localparam int IW = idx_width(CODE_LEN);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = timer_width(TIMEOUT_CYC, LOCKOUT_CYC);
  localparam logic [TW-1:0] c_LOCK_LOAD    = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] c_TIMEOUT_TERM = TW'(TIMEOUT_CYC - 1);

  state_e        state_d, state_q;
  logic [IW-1:0] idx_d, idx_q;
  logic [FW-1:0] fail_d, fail_q;
  logic [CW-1:0] code_d, code_q;
  logic [CW-1:0] shadow_d, shadow_q;

  logic [KEY_W-1:0] w_exp_key;
  logic [CW-1:0]    w_shadow_wr;
  logic [FW-1:0]    w_fail_inc;
  logic [TW-1:0]    w_term;
  logic             w_tc, w_key, w_last, fail_ev;
  logic             t_clr, t_load, t_inc, t_dec;

  assign w_key      = (keys != '0);
  assign w_last     = (idx_q == IW'(CODE_LEN - 1));
  assign w_fail_inc = fail_q + 1'b1;
  assign w_term     = (state_q == ST_LOCKOUT) ? '0 : c_TIMEOUT_TERM;

  // Slot idx of the live code, and the shadow with the current key dropped into slot idx.
  always_comb begin
    w_exp_key   = '0;
    w_shadow_wr = shadow_q;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IW'(i)) begin
        w_exp_key                   = code_q[i*KEY_W +: KEY_W];
        w_shadow_wr[i*KEY_W +: KEY_W] = keys;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    fail_ev  = 1'b0;
    t_clr    = 1'b0;
    t_load   = 1'b0;
    t_inc    = 1'b0;
    t_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_key) begin
          if (keys == w_exp_key) begin
            state_d = ST_ENTER;
            idx_d   = IW'(1);
          end else begin
            fail_ev = 1'b1;
          end
        end
      end
      ST_ENTER: begin
        if (w_key) begin
          if (keys != w_exp_key) begin
            fail_ev = 1'b1;
          end else if (w_last) begin
            state_d = ST_UNLOCKED;
            idx_d   = '0;
            fail_d  = '0;
          end else begin
            idx_d = idx_q + 1'b1;
            t_clr = 1'b1;
          end
        end else if (w_tc) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          t_inc = 1'b1;
        end
      end
      ST_UNLOCKED: begin
        if (lock_cmd) begin
          state_d = ST_IDLE;
        end else if (prog_req) begin
          state_d = ST_PROGRAM;
          idx_d   = '0;
        end
      end
      ST_PROGRAM: begin
        if (lock_cmd) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (w_key) begin
          if (w_last) begin
            code_d  = w_shadow_wr;
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            shadow_d = w_shadow_wr;
            idx_d    = idx_q + 1'b1;
            t_clr    = 1'b1;
          end
        end else if (w_tc) begin
          state_d = ST_UNLOCKED;
          idx_d   = '0;
        end else begin
          t_inc = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (w_tc) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    if (fail_ev) begin
      idx_d   = '0;
      fail_d  = w_fail_inc;
      state_d = (w_fail_inc == FW'(MAX_FAIL)) ? ST_LOCKOUT : ST_IDLE;
    end

    // Any state change restarts the timer; entering lockout preloads the down-count.
    if (state_d != state_q) begin
      t_inc  = 1'b0;
      t_dec  = 1'b0;
      t_clr  = (state_d != ST_LOCKOUT);
      t_load = (state_d == ST_LOCKOUT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      fail_q   <= '0;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (t_clr),
    .i_load     (t_load),
    .i_load_val (c_LOCK_LOAD),
    .i_inc      (t_inc),
    .i_dec      (t_dec),
    .i_term     (w_term),
    .o_tc       (w_tc)
  );

  always_comb begin
    progress = '0;
    if (state_q == ST_UNLOCKED) begin
      progress = '1;
    end else if (state_q == ST_ENTER || state_q == ST_PROGRAM) begin
      for (int i = 0; i < CODE_LEN; i++) progress[i] = (IW'(i) < idx_q);
    end
  end

  assign unlock      = (state_q == ST_UNLOCKED);
  assign programming = (state_q == ST_PROGRAM);
  assign locked_out  = (state_q == ST_LOCKOUT);
  assign fail_cnt    = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_prog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_code_lock_prog : directed scenarios plus random traffic against a model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_code_lock_prog;

  localparam int KEY_W       = 4;
  localparam int CODE_LEN    = 4;
  localparam int TIMEOUT_CYC = 32;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 64;
  localparam logic [15:0] DEF_CODE = 16'h2841;
  localparam logic [15:0] NEW_CODE = 16'h3188;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keys = 4'h0;
  logic       lock_cmd = 1'b0;
  logic       prog_req = 1'b0;
  logic       unlock, programming, locked_out;
  logic [3:0] progress;
  logic [1:0] fail_cnt;
  logic [8:0] obs;

  code_lock_prog #(
    .KEY_W        (KEY_W),
    .CODE_LEN     (CODE_LEN),
    .DEFAULT_CODE (DEF_CODE),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .MAX_FAIL     (MAX_FAIL),
    .LOCKOUT_CYC  (LOCKOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keys        (keys),
    .lock_cmd    (lock_cmd),
    .prog_req    (prog_req),
    .unlock      (unlock),
    .progress    (progress),
    .programming (programming),
    .locked_out  (locked_out),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {unlock, progress, programming, locked_out, fail_cnt};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: modes plus the list of keys accepted so far.
  localparam int M_IDLE = 0, M_ENTER = 1, M_OPEN = 2, M_PROG = 3, M_LOCK = 4;
  int         m_mode, m_got, m_idle, m_fail, m_left;
  logic [3:0] m_code [4];
  logic [3:0] m_shadow [$];

  function automatic void model_reset();
    logic [15:0] d;
    d = DEF_CODE;
    m_mode = M_IDLE; m_got = 0; m_idle = 0; m_fail = 0; m_left = 0;
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = d[i*4 +: 4];
    m_shadow.delete();
  endfunction

  function automatic void model_fail();
    m_fail++;
    m_got = 0;
    if (m_fail == MAX_FAIL) begin
      m_mode = M_LOCK;
      m_left = LOCKOUT_CYC;
    end else begin
      m_mode = M_IDLE;
    end
  endfunction

  function automatic void model_step(input logic [3:0] k, input logic l, input logic p);
    int prev;
    prev = m_mode;
    case (m_mode)
      M_IDLE: if (k != 0) begin
        if (k == m_code[0]) begin m_mode = M_ENTER; m_got = 1; end
        else model_fail();
      end
      M_ENTER: if (k != 0) begin
        if (k == m_code[m_got]) begin
          m_got++;
          m_idle = 0;
          if (m_got == CODE_LEN) begin m_mode = M_OPEN; m_got = 0; m_fail = 0; end
        end else model_fail();
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin m_mode = M_IDLE; m_got = 0; end
      end
      M_OPEN: if (l) m_mode = M_IDLE; else if (p) m_mode = M_PROG;
      M_PROG: if (l) m_mode = M_IDLE;
      else if (k != 0) begin
        m_shadow.push_back(k);
        m_idle = 0;
        if (m_shadow.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_shadow[i];
          m_mode = M_IDLE;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) m_mode = M_OPEN;
      end
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_IDLE; m_fail = 0; end
      end
      default: ;
    endcase
    if (m_mode != prev) begin
      m_idle = 0;
      m_shadow.delete();
    end
  endfunction

  function automatic logic [8:0] exp_out();
    logic [3:0] pr;
    pr = 4'h0;
    if (m_mode == M_OPEN)       pr = 4'hF;
    else if (m_mode == M_ENTER) pr = 4'((1 << m_got) - 1);
    else if (m_mode == M_PROG)  pr = 4'((1 << m_shadow.size()) - 1);
    return {m_mode == M_OPEN, pr, m_mode == M_PROG, m_mode == M_LOCK, 2'(m_fail)};
  endfunction

  task automatic tick(input logic [3:0] k, input logic l, input logic p);
    keys = k; lock_cmd = l; prog_req = p;
    @(posedge clk);
    model_step(k, l, p);
    #1;
    keys = 4'h0; lock_cmd = 1'b0; prog_req = 1'b0;
  endtask

  task automatic send_code(input logic [15:0] seq);
    for (int i = 0; i < CODE_LEN; i++) begin
      tick(seq[i*4 +: 4], 1'b0, 1'b0);
      tick(4'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 9'h000) begin
      $display("FAIL reset_state: got %h want %h", obs, 9'h000);
      miscompares++;
    end
    reset = 1'b0;
  endtask

  task automatic test_unlock();
    logic [15:0] seq;
    seq = DEF_CODE;
    for (int i = 0; i < CODE_LEN; i++) begin
      tick(seq[i*4 +: 4], 1'b0, 1'b0);
      vectors++;
      if (progress !== 4'((1 << (i + 1)) - 1) || obs !== exp_out()) begin
        $display("FAIL unlock_key%0d: got %h want progress %h model %h",
                 i, obs, 4'((1 << (i + 1)) - 1), exp_out());
        miscompares++;
      end
      if (i < CODE_LEN - 1) repeat (3) tick(4'h0, 1'b0, 1'b0);
    end
    vectors++;
    if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
      $display("FAIL unlock_open: got unlock %b fail %0d want 1 0", unlock, fail_cnt);
      miscompares++;
    end
    tick(4'h0, 1'b1, 1'b0);
    vectors++;
    if (obs !== 9'h000) begin
      $display("FAIL relock: got %h want %h", obs, 9'h000);
      miscompares++;
    end
  endtask

  task automatic test_lockout();
    logic [15:0] seq;
    int lo;
    seq = DEF_CODE;
    for (int a = 1; a <= MAX_FAIL; a++) begin
      tick(4'h1, 1'b0, 1'b0);
      tick(4'h2, 1'b0, 1'b0);
      vectors++;
      if (progress !== 4'h0 || fail_cnt !== 2'(a) || locked_out !== (a == MAX_FAIL)) begin
        $display("FAIL fail_attempt%0d: got prog %h fail %0d lo %b want 0 %0d %b",
                 a, progress, fail_cnt, locked_out, a, a == MAX_FAIL);
        miscompares++;
      end
    end
    lo = locked_out ? 1 : 0;
    for (int c = 0; c < 100 && locked_out; c++) begin
      tick((c >= 10 && c < 14) ? seq[(c-10)*4 +: 4] : 4'h0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_out() || unlock !== 1'b0) begin
        $display("FAIL lockout_cyc%0d: got %h want %h", c, obs, exp_out());
        miscompares++;
      end
      if (locked_out) lo++;
    end
    vectors++;
    if (lo !== LOCKOUT_CYC || fail_cnt !== 2'd0) begin
      $display("FAIL lockout_len: got %0d cycles fail %0d want %0d 0", lo, fail_cnt, LOCKOUT_CYC);
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    tick(4'h1, 1'b0, 1'b0);
    tick(4'h4, 1'b0, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      tick(4'h0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_out() || (c == 31 && progress !== 4'h3) ||
          (c == 32 && (progress !== 4'h0 || fail_cnt !== 2'd0))) begin
        $display("FAIL timeout_idle%0d: got %h want %h", c, obs, exp_out());
        miscompares++;
      end
    end
    send_code(DEF_CODE);
    vectors++;
    if (unlock !== 1'b1) begin
      $display("FAIL timeout_reentry: got unlock %b want 1", unlock);
      miscompares++;
    end
  endtask

  task automatic test_program();
    logic [15:0] seq;
    seq = NEW_CODE;
    tick(4'h0, 1'b0, 1'b1);
    vectors++;
    if (programming !== 1'b1 || progress !== 4'h0) begin
      $display("FAIL prog_enter: got prog %b progress %h want 1 0", programming, progress);
      miscompares++;
    end
    for (int i = 0; i < CODE_LEN; i++) begin
      tick(seq[i*4 +: 4], 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_out()) begin
        $display("FAIL prog_key%0d: got %h want %h", i, obs, exp_out());
        miscompares++;
      end
    end
    vectors++;
    if (obs !== 9'h000) begin
      $display("FAIL prog_commit: got %h want %h", obs, 9'h000);
      miscompares++;
    end
    tick(4'h1, 1'b0, 1'b0);
    vectors++;
    if (fail_cnt !== 2'd1 || progress !== 4'h0 || unlock !== 1'b0) begin
      $display("FAIL old_code_rejected: got fail %0d progress %h want 1 0", fail_cnt, progress);
      miscompares++;
    end
    send_code(NEW_CODE);
    vectors++;
    if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
      $display("FAIL new_code_opens: got unlock %b fail %0d want 1 0", unlock, fail_cnt);
      miscompares++;
    end
  endtask

  task automatic test_prog_abort();
    tick(4'h0, 1'b0, 1'b1);
    tick(4'h2, 1'b0, 1'b0);
    tick(4'h3, 1'b0, 1'b0);
    for (int c = 1; c <= TIMEOUT_CYC; c++) begin
      tick(4'h0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_out() || (c == 31 && programming !== 1'b1) ||
          (c == 32 && (unlock !== 1'b1 || progress !== 4'hF))) begin
        $display("FAIL prog_timeout%0d: got %h want %h", c, obs, exp_out());
        miscompares++;
      end
    end
    tick(4'h0, 1'b1, 1'b0);
    send_code(NEW_CODE);
    vectors++;
    if (unlock !== 1'b1) begin
      $display("FAIL code_kept_after_abort: got unlock %b want 1", unlock);
      miscompares++;
    end
    tick(4'h0, 1'b1, 1'b1);
    vectors++;
    if (obs !== 9'h000) begin
      $display("FAIL lock_beats_prog: got %h want %h", obs, 9'h000);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_prog();
    send_code(NEW_CODE);
    tick(4'h0, 1'b0, 1'b1);
    tick(4'h5, 1'b0, 1'b0);
    tick(4'h6, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (obs !== 9'h000) begin
      $display("FAIL async_reset: got %h want %h", obs, 9'h000);
      miscompares++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    send_code(DEF_CODE);
    vectors++;
    if (unlock !== 1'b1) begin
      $display("FAIL default_after_reset: got unlock %b want 1", unlock);
      miscompares++;
    end
    tick(4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] k;
    logic l, p;
    int r;
    bit sparse;
    for (int c = 0; c < 3000; c++) begin
      k = 4'h0; l = 1'b0; p = 1'b0;
      sparse = ((c / 400) % 2) == 1;
      r = $urandom_range(0, 99);
      if (!(sparse && $urandom_range(0, 9) != 0)) begin
        if (r < 35)      k = (m_mode == M_ENTER) ? m_code[m_got] : m_code[0];
        else if (r < 45) k = 4'($urandom);
        else if (r < 48) l = 1'b1;
        else if (r < 52) p = 1'b1;
      end
      tick(k, l, p);
      vectors++;
      if (obs !== exp_out()) begin
        $display("FAIL random_cyc%0d: got %h want %h", c, obs, exp_out());
        miscompares++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout();
    test_program();
    test_prog_abort();
    test_reset_mid_prog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
